// File: rtl/wdt_cfg_sequencer_if.sv
// FIFO read-side bus between the CPU->WDT async FIFO and the watchdog config sequencer.
// master = popping side (sequencer), slave = FIFO read port.
interface wdt_cfg_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              fifo_rempty;
  logic [DATA_W+1:0] fifo_rdata;
  logic              fifo_rinc;

  modport master (
    input  fifo_rempty,
    input  fifo_rdata,
    output fifo_rinc
  );

  modport slave (
    output fifo_rempty,
    output fifo_rdata,
    input  fifo_rinc
  );
endinterface

// File: rtl/wdt_cfg_sequencer.sv
// Watchdog config sequencer (clk2 domain): pops {addr,data} entries, issues one-cycle
// enable/live/threshold updates, auto-clears the live kick and tracks timeout interrupts.
module wdt_cfg_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LIVE_HOLD = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk2,
  input  logic               rst2,
  wdt_cfg_sequencer_if.master fifo,
  output logic               WDEN,
  output logic               WDEN_valid,
  output logic               WDLIVE,
  output logic               WDLIVE_valid,
  output logic [DATA_W-1:0]  WTOCNT,
  output logic               WTOCNT_valid,
  output logic               wdt_hold,
  input  logic               WTO_interrupt,
  output logic               irq_pending,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic               cfg_err
);

  localparam int unsigned HOLD_W = (LIVE_HOLD > 1) ? $clog2(LIVE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (LIVE_HOLD > 0) ? HOLD_W'(LIVE_HOLD - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_ISSUE,
    S_HOLD,
    S_CLR
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          addr_q, addr_d;
  logic                d0_q, d0_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                wden_q, wden_d;
  logic                wdlive_q, wdlive_d;
  logic [DATA_W-1:0]   wtocnt_q, wtocnt_d;
  logic                wto_prev_q, wto_prev_d;
  logic                irq_q, irq_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic                rinc;
  logic                irq_clr;
  logic                wto_rise;

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      d0_q       <= 1'b0;
      hold_cnt_q <= '0;
      wden_q     <= 1'b0;
      wdlive_q   <= 1'b0;
      wtocnt_q   <= '0;
      wto_prev_q <= 1'b0;
      irq_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      d0_q       <= d0_d;
      hold_cnt_q <= hold_cnt_d;
      wden_q     <= wden_d;
      wdlive_q   <= wdlive_d;
      wtocnt_q   <= wtocnt_d;
      wto_prev_q <= wto_prev_d;
      irq_q      <= irq_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    d0_d         = d0_q;
    hold_cnt_d   = hold_cnt_q;
    wden_d       = wden_q;
    wdlive_d     = wdlive_q;
    wtocnt_d     = wtocnt_q;
    rinc         = 1'b0;
    WDEN_valid   = 1'b0;
    WDLIVE_valid = 1'b0;
    WTOCNT_valid = 1'b0;
    cfg_err      = 1'b0;
    irq_clr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo.fifo_rempty) state_d = S_POP;
      end
      // Value registers load on the pop edge so they already show the new value
      // in the ISSUE cycle and simply hold it afterwards.
      S_POP: begin
        rinc   = 1'b1;
        addr_d = fifo.fifo_rdata[DATA_W+1:DATA_W];
        d0_d   = fifo.fifo_rdata[0];
        case (fifo.fifo_rdata[DATA_W+1:DATA_W])
          2'd0:    wden_d   = fifo.fifo_rdata[0];
          2'd1:    wdlive_d = fifo.fifo_rdata[0];
          2'd2:    wtocnt_d = fifo.fifo_rdata[DATA_W-1:0];
          default: ;
        endcase
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        case (addr_q)
          2'd0:    WDEN_valid   = 1'b1;
          2'd1:    WDLIVE_valid = 1'b1;
          2'd2:    WTOCNT_valid = 1'b1;
          default: begin
            irq_clr = d0_q;
            cfg_err = ~d0_q;
          end
        endcase
        if ((addr_q == 2'd1) && d0_q && (LIVE_HOLD > 0)) begin
          state_d    = S_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else if (!fifo.fifo_rempty) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      // WDLIVE stays 1 for LIVE_HOLD cycles between the kick and the auto-clear strobe.
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d  = S_CLR;
          wdlive_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      S_CLR: begin
        WDLIVE_valid = 1'b1;
        state_d      = fifo.fifo_rempty ? S_IDLE : S_POP;
      end
      default: state_d = S_IDLE;
    endcase

    wdt_hold = ~(WDEN_valid | WDLIVE_valid | WTOCNT_valid);
  end

  // A new timeout edge takes priority over a same-cycle IRQ_CLR.
  always_comb begin
    wto_prev_d = WTO_interrupt;
    wto_rise   = WTO_interrupt & ~wto_prev_q;
    irq_d      = irq_q;
    tcnt_d     = tcnt_q;
    if (wto_rise) begin
      irq_d = 1'b1;
      if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  assign fifo.fifo_rinc = rinc;
  assign WDEN           = wden_q;
  assign WDLIVE         = wdlive_q;
  assign WTOCNT         = wtocnt_q;
  assign irq_pending    = irq_q;
  assign timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_wdt_cfg_sequencer.sv
// Directed bench for wdt_cfg_sequencer: a queue stands in for the FIFO read side and
// every step compares outputs against hand-computed values.
module tb_wdt_cfg_sequencer;

  logic        clk2;
  logic        rst2;
  logic        WDEN, WDEN_valid, WDLIVE, WDLIVE_valid, WTOCNT_valid, wdt_hold;
  logic [31:0] WTOCNT;
  logic        WTO_interrupt;
  logic        irq_pending;
  logic [7:0]  timeout_cnt;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [33:0] q[$];

  wdt_cfg_sequencer_if #(.DATA_W(32)) fif ();

  wdt_cfg_sequencer #(
    .DATA_W   (32),
    .LIVE_HOLD(4),
    .CNT_W    (8)
  ) dut (
    .clk2         (clk2),
    .rst2         (rst2),
    .fifo         (fif),
    .WDEN         (WDEN),
    .WDEN_valid   (WDEN_valid),
    .WDLIVE       (WDLIVE),
    .WDLIVE_valid (WDLIVE_valid),
    .WTOCNT       (WTOCNT),
    .WTOCNT_valid (WTOCNT_valid),
    .wdt_hold     (wdt_hold),
    .WTO_interrupt(WTO_interrupt),
    .irq_pending  (irq_pending),
    .timeout_cnt  (timeout_cnt),
    .cfg_err      (cfg_err)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // {rinc, WDEN_valid, WDLIVE_valid, WTOCNT_valid, cfg_err, wdt_hold}
  function automatic logic [5:0] strb();
    return {fif.fifo_rinc, WDEN_valid, WDLIVE_valid, WTOCNT_valid, cfg_err, wdt_hold};
  endfunction

  function automatic logic [33:0] ent(input logic [1:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fif.fifo_rempty = (q.size() == 0);
    fif.fifo_rdata  = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [33:0] e);
    q.push_back(e);
    refresh();
  endtask

  // Advance one clock; the FIFO model pops when rinc was high in the cycle just ended.
  task automatic tick();
    logic p;
    p = fif.fifo_rinc;
    @(posedge clk2);
    #1;
    if (p) begin
      chk("rinc_while_empty", 64'(q.size() == 0), 64'd0);
      if (q.size() != 0) void'(q.pop_front());
    end
    refresh();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst2          = 1'b1;
    WTO_interrupt = 1'b0;
    refresh();
    repeat (3) @(posedge clk2);
    #1;
    chk("rst_strb",   64'(strb()),      64'b000001);
    chk("rst_wden",   64'(WDEN),        64'd0);
    chk("rst_wdlive", 64'(WDLIVE),      64'd0);
    chk("rst_wtocnt", 64'(WTOCNT),      64'd0);
    chk("rst_irq",    64'(irq_pending), 64'd0);
    chk("rst_tcnt",   64'(timeout_cnt), 64'd0);
    rst2 = 1'b0;
    tick();
    chk("idle_strb", 64'(strb()), 64'b000001);

    // WTOCNT then WDEN back-to-back: strobes at t+2 and t+4
    push(ent(2'd2, 32'd100));
    push(ent(2'd0, 32'd1));
    chk("t1_t0", 64'(strb()), 64'b000001);
    tick(); chk("t1_pop1",   64'(strb()), 64'b100001);
    tick(); chk("t1_iss1",   64'(strb()), 64'b000100);
            chk("t1_wtocnt", 64'(WTOCNT), 64'd100);
    tick(); chk("t1_pop2",   64'(strb()), 64'b100001);
    tick(); chk("t1_iss2",   64'(strb()), 64'b010000);
            chk("t1_wden",   64'(WDEN),   64'd1);
            chk("t1_wtohold",64'(WTOCNT), 64'd100);
    tick(); chk("t1_idle",   64'(strb()), 64'b000001);

    // Live kick with auto-clear after LIVE_HOLD cycles
    push(ent(2'd1, 32'd1));
    tick(); chk("t2_pop",    64'(strb()), 64'b100001);
    tick(); chk("t2_iss",    64'(strb()), 64'b001000);
            chk("t2_live1",  64'(WDLIVE), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t2_hold", 64'(strb()), 64'b000001);
              chk("t2_holdv",64'(WDLIVE), 64'd1);
    end
    tick(); chk("t2_clr",    64'(strb()), 64'b001000);
            chk("t2_live0",  64'(WDLIVE), 64'd0);
    tick(); chk("t2_idle",   64'(strb()), 64'b000001);

    // Kick followed by WDEN=0: second entry waits for the auto-clear
    push(ent(2'd1, 32'd1));
    push(ent(2'd0, 32'd0));
    tick(); chk("t3_pop",    64'(strb()), 64'b100001);
    tick(); chk("t3_iss",    64'(strb()), 64'b001000);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t3_hold_norinc", 64'(strb()), 64'b000001);
    end
    tick(); chk("t3_clr",    64'(strb()), 64'b001000);
            chk("t3_wdenold",64'(WDEN),   64'd1);
    tick(); chk("t3_pop2",   64'(strb()), 64'b100001);
    tick(); chk("t3_iss2",   64'(strb()), 64'b010000);
            chk("t3_wden0",  64'(WDEN),   64'd0);
    tick(); chk("t3_idle",   64'(strb()), 64'b000001);

    // Undecodable {3,0} then a normal entry
    push(ent(2'd3, 32'd0));
    push(ent(2'd2, 32'd7));
    tick(); chk("t4_pop",    64'(strb()), 64'b100001);
    tick(); chk("t4_err",    64'(strb()), 64'b000011);
            chk("t4_wto",    64'(WTOCNT), 64'd100);
    tick(); chk("t4_pop2",   64'(strb()), 64'b100001);
    tick(); chk("t4_iss2",   64'(strb()), 64'b000100);
            chk("t4_wtocnt", 64'(WTOCNT), 64'd7);
    tick(); chk("t4_idle",   64'(strb()), 64'b000001);

    // Timeout edges: 300 rises saturate the 8-bit counter
    WTO_interrupt = 1'b1;
    tick(); chk("t5_irq1",   64'(irq_pending), 64'd1);
            chk("t5_cnt1",   64'(timeout_cnt), 64'd1);
    WTO_interrupt = 1'b0;
    tick(); chk("t5_cntlvl", 64'(timeout_cnt), 64'd1);
    for (int i = 0; i < 299; i++) begin
      WTO_interrupt = 1'b1; tick();
      WTO_interrupt = 1'b0; tick();
    end
    chk("t5_sat",  64'(timeout_cnt), 64'd255);
    chk("t5_irq",  64'(irq_pending), 64'd1);

    push(ent(2'd3, 32'd1));
    tick(); chk("t5_clrpop", 64'(strb()),      64'b100001);
    tick(); chk("t5_clriss", 64'(strb()),      64'b000001);
            chk("t5_irqiss", 64'(irq_pending), 64'd1);
    tick(); chk("t5_irqclr", 64'(irq_pending), 64'd0);
            chk("t5_cntkeep",64'(timeout_cnt), 64'd255);

    // Rising edge in the same cycle as IRQ_CLR: set wins
    push(ent(2'd3, 32'd1));
    tick();
    tick(); chk("t5_swiss",  64'(strb()), 64'b000001);
    WTO_interrupt = 1'b1;
    tick(); chk("t5_setwins",64'(irq_pending), 64'd1);
            chk("t5_cntsat2",64'(timeout_cnt), 64'd255);
    WTO_interrupt = 1'b0;
    tick();

    // Reset mid-HOLD drops the pending auto-clear
    push(ent(2'd1, 32'd1));
    tick();
    tick(); chk("t6_iss",    64'(strb()), 64'b001000);
    tick();
    rst2 = 1'b1;
    #1;
    chk("t6_strb",   64'(strb()),      64'b000001);
    chk("t6_wdlive", 64'(WDLIVE),      64'd0);
    chk("t6_irq",    64'(irq_pending), 64'd0);
    chk("t6_tcnt",   64'(timeout_cnt), 64'd0);
    chk("t6_wden",   64'(WDEN),        64'd0);
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("t6_noclr", 64'(strb()), 64'b000001);
    end

    push(ent(2'd0, 32'd1));
    tick(); chk("t7_pop",  64'(strb()), 64'b100001);
    tick(); chk("t7_iss",  64'(strb()), 64'b010000);
            chk("t7_wden", 64'(WDEN),   64'd1);
    tick(); chk("t7_idle", 64'(strb()), 64'b000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
